// File: rtl/ha_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ha_bist_pkg
// Description : Shared constants for the half-adder BIST engine.
// Revision    : 1.0 - initial release
// ============================================================================
package ha_bist_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DRIVE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int UI_START    = 0;
  localparam int UI_EXT_MODE = 1;
  localparam int UI_INJECT   = 2;
  localparam int UI_SWEEP_LO = 4;

  localparam int UO_BUSY   = 0;
  localparam int UO_DONE   = 1;
  localparam int UO_PASS   = 2;
  localparam int UO_FAIL   = 3;
  localparam int UO_ERR_LO = 4;

  localparam int UIO_A     = 0;
  localparam int UIO_B     = 1;
  localparam int UIO_SUM   = 2;
  localparam int UIO_CARRY = 3;

  localparam logic [7:0] UIO_OE_VAL = 8'h03;
  localparam logic [3:0] ERR_MAX    = 4'd15;

endpackage
`default_nettype wire

// File: rtl/ha_cell.sv
`default_nettype none
// ============================================================================
// Module      : ha_cell
// Description : Combinational half adder used as the internal device under test.
// Revision    : 1.0 - initial release
// ============================================================================
module ha_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule
`default_nettype wire

// File: rtl/tt_um_halfrahna_bist.sv
`default_nettype none
// ============================================================================
// Module      : tt_um_halfrahna_bist
// Description : BIST engine sweeping all a/b vectors through a half adder.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_um_halfrahna_bist
  import ha_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [3:0] c_settle = 4'(SETTLE_CYCLES);

  logic [2:0] r_state;
  logic       r_start_q;
  logic       r_ext_mode;
  logic       r_inject;
  logic [4:0] r_sweep_left;
  logic [1:0] r_vec;
  logic       r_a;
  logic       r_b;
  logic [3:0] r_settle_cnt;
  logic [3:0] r_err_cnt;
  logic       r_done;
  logic       r_pass;
  logic       r_fail;

  logic       w_start_edge;
  logic       w_ha_sum;
  logic       w_ha_carry;
  logic [1:0] w_observed;
  logic [1:0] w_golden;
  logic       w_mismatch;
  logic [3:0] w_err_next;
  logic [4:0] w_sweep_n;
  logic       w_busy;
  logic       w_unused;

  ha_cell u_ha_cell (
    .a     (r_a),
    .b     (r_b),
    .sum   (w_ha_sum),
    .carry (w_ha_carry)
  );

  assign w_start_edge = ui_in[UI_START] & ~r_start_q;
  assign w_sweep_n    = (ui_in[UI_SWEEP_LO +: 4] == 4'd0) ? 5'd16
                                                          : {1'b0, ui_in[UI_SWEEP_LO +: 4]};

  // Fault inversion sits outside ha_cell so the external path is never affected.
  assign w_observed = r_ext_mode ? {uio_in[UIO_CARRY], uio_in[UIO_SUM]}
                                 : {w_ha_carry, w_ha_sum ^ r_inject};
  assign w_golden   = {r_a & r_b, r_a ^ r_b};
  assign w_mismatch = (w_observed != w_golden);
  assign w_err_next = (w_mismatch && (r_err_cnt != ERR_MAX)) ? r_err_cnt + 4'd1 : r_err_cnt;

  assign w_busy = (r_state == ST_DRIVE) || (r_state == ST_WAIT) || (r_state == ST_CHECK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_start_q    <= 1'b0;
      r_ext_mode   <= 1'b0;
      r_inject     <= 1'b0;
      r_sweep_left <= 5'd0;
      r_vec        <= 2'd0;
      r_a          <= 1'b0;
      r_b          <= 1'b0;
      r_settle_cnt <= 4'd0;
      r_err_cnt    <= 4'd0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail       <= 1'b0;
    end else if (ena) begin
      r_start_q <= ui_in[UI_START];
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start_edge) begin
            r_sweep_left <= w_sweep_n;
            r_ext_mode   <= ui_in[UI_EXT_MODE];
            r_inject     <= ui_in[UI_INJECT];
            r_err_cnt    <= 4'd0;
            r_vec        <= 2'd0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail       <= 1'b0;
            r_state      <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          r_a          <= r_vec[0];
          r_b          <= r_vec[1];
          r_settle_cnt <= c_settle;
          r_state      <= ST_WAIT;
        end
        ST_WAIT: begin
          r_settle_cnt <= r_settle_cnt - 4'd1;
          if (r_settle_cnt <= 4'd1) begin
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          r_err_cnt <= w_err_next;
          r_vec     <= r_vec + 2'd1;
          r_state   <= ST_DRIVE;
          if (r_vec == 2'd3) begin
            r_sweep_left <= r_sweep_left - 5'd1;
            // Result flags are published together with the final error count.
            if (r_sweep_left == 5'd1) begin
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == 4'd0);
              r_fail  <= (w_err_next != 4'd0);
              r_state <= ST_DONE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    uo_out                   = 8'h00;
    uo_out[UO_BUSY]          = w_busy;
    uo_out[UO_DONE]          = r_done;
    uo_out[UO_PASS]          = r_pass;
    uo_out[UO_FAIL]          = r_fail;
    uo_out[UO_ERR_LO +: 4]   = r_err_cnt;
    uio_out                  = 8'h00;
    uio_out[UIO_A]           = r_a;
    uio_out[UIO_B]           = r_b;
  end

  assign uio_oe   = UIO_OE_VAL;
  assign w_unused = &{1'b0, ui_in[3], uio_in[7:4], uio_in[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_tt_um_halfrahna_bist.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_um_halfrahna_bist
// Description : Self-checking bench for the half-adder BIST engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_um_halfrahna_bist;

  localparam int SETTLE = 2;
  localparam int VEC_CYC = SETTLE + 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int vectors = 0;
  int miscompares = 0;

  // 0: correct external half adder, 1: carry stuck at 1, 2: sum stuck at 0
  int ext_fault = 0;

  int         busy_cyc;
  int         post_busy;
  int         freeze_bad;
  logic       timed_out;
  logic [1:0] ab_rec [4];

  tt_um_halfrahna_bist #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  always_comb begin
    logic s, c;
    s = uio_out[0] ^ uio_out[1];
    c = uio_out[0] & uio_out[1];
    if (ext_fault == 1) c = 1'b1;
    if (ext_fault == 2) s = 1'b0;
    uio_in = {4'b0000, c, s, 2'b00};
  end

  // Reference: count wrong vectors over the whole sweep, then saturate.
  function automatic logic [7:0] model_uo(input logic [3:0] n, input logic ext,
                                          input logic inj, input int fault);
    int nv, errs;
    logic a, b, gs, gc, os, oc;
    nv = ((n == 4'd0) ? 16 : int'(n)) * 4;
    errs = 0;
    for (int i = 0; i < nv; i++) begin
      a = (i % 4) % 2 == 1;
      b = (i % 4) / 2 == 1;
      gs = a ^ b;
      gc = a & b;
      if (ext) begin
        os = (fault == 2) ? 1'b0 : gs;
        oc = (fault == 1) ? 1'b1 : gc;
      end else begin
        os = gs ^ inj;
        oc = gc;
      end
      if (os != gs || oc != gc) errs++;
    end
    if (errs > 15) errs = 15;
    return {4'(errs), errs != 0, errs == 0, 1'b1, 1'b0};
  endfunction

  function automatic int model_busy(input logic [3:0] n);
    return ((n == 4'd0) ? 16 : int'(n)) * 4 * VEC_CYC;
  endfunction

  task automatic do_run(input logic [3:0] n, input logic ext, input logic inj,
                        input logic hold, input int glitch_at, input int ena_at);
    logic [15:0] snap;
    busy_cyc = 0; post_busy = 0; freeze_bad = 0; timed_out = 1'b1;
    for (int v = 0; v < 4; v++) ab_rec[v] = 2'bxx;
    @(negedge clk);
    ui_in = {n, 1'b0, inj, ext, 1'b1};
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (uo_out[1] && !uo_out[0]) begin
        timed_out = 1'b0;
        break;
      end
      if (uo_out[0]) begin
        if (ena_at < 0 && busy_cyc % VEC_CYC == 1 && busy_cyc / VEC_CYC < 4)
          ab_rec[busy_cyc / VEC_CYC] = uio_out[1:0];
        busy_cyc++;
      end
      if (!hold) ui_in[0] = 1'b0;
      if (busy_cyc == glitch_at) ui_in[0] = 1'b1;
      if (busy_cyc == ena_at) begin
        snap = {uo_out, uio_out};
        ena = 1'b0;
        repeat (10) begin
          @(negedge clk);
          if (uo_out[0]) busy_cyc++;
          if ({uo_out, uio_out} !== snap) freeze_bad++;
        end
        ena = 1'b1;
      end
    end
    if (hold) repeat (6) begin
      @(negedge clk);
      if (uo_out[0]) post_busy++;
    end
    ui_in[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00;
    repeat (3) @(negedge clk);
    vectors++;
    if (uo_out !== 8'h00) begin
      miscompares++; $display("FAIL reset_uo: got %h expected 00", uo_out);
    end
    vectors++;
    if (uio_oe !== 8'h03) begin
      miscompares++; $display("FAIL reset_oe: got %h expected 03", uio_oe);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
      miscompares++; $display("FAIL reset_idle: got uo=%h uio=%h expected 00/00", uo_out, uio_out);
    end
  endtask

  task automatic test_clean_internal();
    ext_fault = 0;
    do_run(4'd1, 1'b0, 1'b0, 1'b0, -1, -1);
    vectors++;
    if (timed_out) begin miscompares++; $display("FAIL clean_timeout: got timeout expected done"); end
    vectors++;
    if (busy_cyc != model_busy(4'd1)) begin
      miscompares++; $display("FAIL clean_busy: got %0d expected %0d", busy_cyc, model_busy(4'd1));
    end
    for (int v = 0; v < 4; v++) begin
      vectors++;
      if (ab_rec[v] !== 2'(v)) begin
        miscompares++; $display("FAIL clean_ab[%0d]: got %b expected %b", v, ab_rec[v], 2'(v));
      end
    end
    vectors++;
    if (uo_out !== 8'h06) begin miscompares++; $display("FAIL clean_uo: got %h expected 06", uo_out); end
  endtask

  task automatic test_fault_injection();
    do_run(4'd1, 1'b0, 1'b1, 1'b0, -1, -1);
    vectors++;
    if (timed_out || uo_out !== 8'h4A) begin
      miscompares++; $display("FAIL inject_n1: got %h expected 4a", uo_out);
    end
    do_run(4'd0, 1'b0, 1'b1, 1'b0, -1, -1);
    vectors++;
    if (timed_out || uo_out !== 8'hFA) begin
      miscompares++; $display("FAIL inject_n16: got %h expected fa", uo_out);
    end
    vectors++;
    if (busy_cyc != 256) begin miscompares++; $display("FAIL inject_n16_busy: got %0d expected 256", busy_cyc); end
  endtask

  task automatic test_restart_in_done();
    int to;
    @(negedge clk);
    ui_in = 8'h11;
    @(negedge clk);
    ui_in[0] = 1'b0;
    vectors++;
    if (uo_out !== 8'h01) begin miscompares++; $display("FAIL restart_clear: got %h expected 01", uo_out); end
    to = 0;
    while (!(uo_out[1] && !uo_out[0]) && to < 500) begin @(negedge clk); to++; end
    vectors++;
    if (uo_out !== 8'h06) begin miscompares++; $display("FAIL restart_result: got %h expected 06", uo_out); end
  endtask

  task automatic test_external();
    ext_fault = 0;
    do_run(4'd2, 1'b1, 1'b1, 1'b0, -1, -1);
    vectors++;
    if (timed_out || uo_out !== 8'h06) begin miscompares++; $display("FAIL ext_pass: got %h expected 06", uo_out); end
    ext_fault = 1;
    do_run(4'd1, 1'b1, 1'b0, 1'b0, -1, -1);
    vectors++;
    if (timed_out || uo_out !== 8'h3A) begin miscompares++; $display("FAIL ext_carry1: got %h expected 3a", uo_out); end
    ext_fault = 0;
  endtask

  task automatic test_start_handling();
    do_run(4'd1, 1'b0, 1'b0, 1'b1, -1, -1);
    vectors++;
    if (timed_out || busy_cyc != 16 || post_busy != 0 || uo_out !== 8'h06) begin
      miscompares++; $display("FAIL start_held: got busy=%0d post=%0d uo=%h expected 16/0/06", busy_cyc, post_busy, uo_out);
    end
    do_run(4'd1, 1'b0, 1'b1, 1'b0, 5, -1);
    vectors++;
    if (timed_out || busy_cyc != 16 || uo_out !== 8'h4A) begin
      miscompares++; $display("FAIL start_midrun: got busy=%0d uo=%h expected 16/4a", busy_cyc, uo_out);
    end
  endtask

  task automatic test_ena_low();
    do_run(4'd1, 1'b0, 1'b1, 1'b0, -1, 6);
    vectors++;
    if (timed_out || busy_cyc != 26) begin miscompares++; $display("FAIL ena_busy: got %0d expected 26", busy_cyc); end
    vectors++;
    if (freeze_bad != 0) begin miscompares++; $display("FAIL ena_freeze: got %0d changes expected 0", freeze_bad); end
    vectors++;
    if (uo_out !== 8'h4A) begin miscompares++; $display("FAIL ena_result: got %h expected 4a", uo_out); end
  endtask

  task automatic test_reset_mid_run();
    int cnt, to;
    @(negedge clk);
    ui_in = 8'h11;
    cnt = 0; to = 0;
    while (cnt < 2 * VEC_CYC + 2 && to < 200) begin
      @(negedge clk);
      ui_in[0] = 1'b0;
      if (uo_out[0]) cnt++;
      to++;
    end
    vectors++;
    if (uio_out[1:0] !== 2'b10) begin miscompares++; $display("FAIL rst_pre_ab: got %b expected 10", uio_out[1:0]); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h03) begin
      miscompares++; $display("FAIL rst_async: got uo=%h uio=%h oe=%h expected 00/00/03", uo_out, uio_out, uio_oe);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (uo_out !== 8'h00) begin miscompares++; $display("FAIL rst_after: got %h expected 00", uo_out); end
  endtask

  task automatic test_random();
    logic [3:0] n;
    logic ext, inj;
    logic [7:0] exp_uo;
    for (int r = 0; r < 10; r++) begin
      n = 4'($urandom_range(0, 5));
      ext = 1'($urandom_range(0, 1));
      inj = 1'($urandom_range(0, 1));
      ext_fault = $urandom_range(0, 2);
      exp_uo = model_uo(n, ext, inj, ext_fault);
      do_run(n, ext, inj, 1'b0, -1, -1);
      vectors++;
      if (timed_out || uo_out !== exp_uo || busy_cyc != model_busy(n)) begin
        miscompares++;
        $display("FAIL random[%0d] n=%0d ext=%0d inj=%0d f=%0d: got uo=%h busy=%0d expected uo=%h busy=%0d",
                 r, n, ext, inj, ext_fault, uo_out, busy_cyc, exp_uo, model_busy(n));
      end
    end
    ext_fault = 0;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00;
    test_reset();
    test_clean_internal();
    test_fault_injection();
    test_restart_in_done();
    test_external();
    test_start_handling();
    test_ena_low();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
